// File: rtl/dsam_decoder.sv
// dsam_decoder: receive-side inverse of the dsam_encoder.
// Each word carries a channel tag in its low ADDR_WIDTH bits. The payload is
// XORed with that channel's last encoded payload to recover the data.
// Words pass through one registered valid/ready stage.
// Optional feature: define DSAM_DECODER_CLEAR_EN to add a synchronous 'clear'
// input that zeroes every channel state.
module dsam_decoder #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 16,
    parameter int CHANNELS   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  out_valid,
`ifdef DSAM_DECODER_CLEAR_EN
    input  logic                  clear,
`endif
    input  logic                  out_ready
);

    localparam int PayloadWidth = DATA_WIDTH - ADDR_WIDTH;

    logic [PayloadWidth-1:0] state_q [CHANNELS];
    logic [PayloadWidth-1:0] state_d [CHANNELS];
    logic [DATA_WIDTH-1:0]   out_q, out_d;
    logic                    outValid_q, outValid_d;

    logic [ADDR_WIDTH-1:0]   ch;
    logic [PayloadWidth-1:0] encPayload;
    logic                    accept;
    logic                    clearNow;

    assign ch         = in[ADDR_WIDTH-1:0];
    assign encPayload = in[DATA_WIDTH-1:ADDR_WIDTH];
    assign in_ready   = !outValid_q || out_ready;
    assign accept     = in_valid && in_ready;
    assign out        = out_q;
    assign out_valid  = outValid_q;

`ifdef DSAM_DECODER_CLEAR_EN
    assign clearNow = clear;
`else
    assign clearNow = 1'b0;
`endif

    // Output stage: load on accept, drop valid when taken without a refill.
    always_comb begin
        out_d      = out_q;
        outValid_d = outValid_q;
        if (accept) begin
            out_d      = {encPayload ^ state_q[ch], ch};
            outValid_d = 1'b1;
        end else if (out_ready) begin
            outValid_d = 1'b0;
        end
    end

    // Channel state: clear wins over the write of an accepted word.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
        end
        if (clearNow) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_d[i] = '0;
            end
        end else if (accept) begin
            state_d[ch] = encPayload;
        end
    end

    // Register all state; reset restarts the stream from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q      <= '0;
            outValid_q <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= '0;
            end
        end else begin
            out_q      <= out_d;
            outValid_q <= outValid_d;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_d[i];
            end
        end
    end

endmodule

// File: tb/tb_dsam_decoder.sv
// tb_dsam_decoder: self-checking bench for dsam_decoder.
// Directed vectors from a table, a backpressure sequence, then a randomized
// round trip through an encoder model kept in the bench.
module tb_dsam_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out;
    logic        out_valid;
    logic        out_ready;
`ifdef DSAM_DECODER_CLEAR_EN
    logic        clear;
`endif

    int passCount = 0;
    int checkCount = 0;

    dsam_decoder #(.ADDR_WIDTH(2), .DATA_WIDTH(16), .CHANNELS(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .in       (in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out      (out),
        .out_valid(out_valid),
`ifdef DSAM_DECODER_CLEAR_EN
        .clear    (clear),
`endif
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        doReset;
        logic [15:0] inWord;
        logic [15:0] expOut;
    } vec_t;

    vec_t vecs [8];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            passCount++;
        end
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Present one word with out_ready high; return #1 after the accepting edge.
    task automatic applyStimulus(input logic [15:0] word);
        in        = word;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
    endtask

    // Encoder model state and bookkeeping for the round trip.
    logic [13:0] encState [4];
    logic [15:0] data;
    logic [15:0] expOut;
    logic        expValid;
    logic        expReady;
    logic        havePending;
    logic        cleared;
    int          accepted;
    int          cycles;

    initial begin
        vecs[0] = '{1'b1, 16'h6394, 16'h6394};
        vecs[1] = '{1'b0, 16'h0624, 16'h65B0};
        vecs[2] = '{1'b0, 16'hFFFC, 16'hF9D8};
        vecs[3] = '{1'b1, 16'h6394, 16'h6394};
        vecs[4] = '{1'b0, 16'h1235, 16'h1235};
        vecs[5] = '{1'b0, 16'h0624, 16'h65B0};
        vecs[6] = '{1'b1, 16'h6394, 16'h6394};
        vecs[7] = '{1'b1, 16'h0624, 16'h0624};

        reset     = 1'b1;
        in        = 16'h1234;
        in_valid  = 1'b1;
        out_ready = 1'b0;
`ifdef DSAM_DECODER_CLEAR_EN
        clear     = 1'b0;
`endif

        // Reset with a word offered: nothing may be captured.
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("resetOut", 32'(out), 32'h0);
            checkOutput("resetValid", 32'(out_valid), 32'h0);
            checkOutput("resetReady", 32'(in_ready), 32'h1);
            @(posedge clk);
        end
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;

        // Directed table: back-to-back, channel independence, mid-stream reset.
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].doReset) pulseReset();
            applyStimulus(vecs[i].inWord);
            checkOutput($sformatf("vecOut%0d", i), 32'(out), 32'(vecs[i].expOut));
            checkOutput($sformatf("vecValid%0d", i), 32'(out_valid), 32'h1);
        end

        // Drain: taken with no refill clears valid and keeps out.
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("drainValid", 32'(out_valid), 32'h0);
        checkOutput("drainOut", 32'(out), 32'h0624);

        // Backpressure: hold three cycles, nothing accepted, state untouched.
        pulseReset();
        applyStimulus(16'h6394);
        in        = 16'h0624;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("bpReady", 32'(in_ready), 32'h0);
            checkOutput("bpOut", 32'(out), 32'h6394);
            checkOutput("bpValid", 32'(out_valid), 32'h1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        checkOutput("bpReleaseReady", 32'(in_ready), 32'h1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("bpReleaseOut", 32'(out), 32'h65B0);
        checkOutput("bpReleaseValid", 32'(out_valid), 32'h1);

        // Randomized round trip against the encoder model.
        pulseReset();
        for (int i = 0; i < 4; i++) encState[i] = '0;
        expOut      = '0;
        expValid    = 1'b0;
        havePending = 1'b0;
        cleared     = 1'b0;
        accepted    = 0;
        cycles      = 0;
        data        = '0;
        while (accepted < 1000 && cycles < 8000) begin
            checkOutput("rtValid", 32'(out_valid), 32'(expValid));
            if (expValid) checkOutput("rtOut", 32'(out), 32'(expOut));
            if (!havePending) begin
                data        = 16'($urandom);
                havePending = 1'b1;
            end
            in        = {data[15:2] ^ encState[data[1:0]], data[1:0]};
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
`ifdef DSAM_DECODER_CLEAR_EN
            if (accepted == 500 && !cleared) begin
                in_valid = 1'b0;
                clear    = 1'b1;
                cleared  = 1'b1;
                for (int i = 0; i < 4; i++) encState[i] = '0;
            end
`endif
            expReady = !expValid || out_ready;
            #1;
            checkOutput("rtReady", 32'(in_ready), 32'(expReady));
            if (in_valid && expReady) begin
                encState[data[1:0]] = in[15:2];
                expOut      = data;
                expValid    = 1'b1;
                havePending = 1'b0;
                accepted++;
            end else if (out_ready) begin
                expValid = 1'b0;
            end
            @(posedge clk);
            #1;
`ifdef DSAM_DECODER_CLEAR_EN
            clear = 1'b0;
`endif
            cycles++;
        end
        in_valid = 1'b0;
        checkOutput("rtAcceptedCount", 32'(accepted), 32'd1000);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
